// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, FSM encoding and legality check for the ALU issue controller
package alu_pkg;

  localparam int NREGS_DEF = 32;
  localparam int DW_DEF    = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  function automatic logic is_legal(input logic [5:0] opcode, input logic [5:0] funct);
    logic w_fn_ok;
    w_fn_ok = (funct == FN_AND) || (funct == FN_OR) || (funct == FN_ADD) ||
              (funct == FN_SUB) || (funct == FN_SLT);
    return (opcode == OP_RTYPE) && w_fn_ok;
  endfunction

endpackage

// File: rtl/issue_regfile.sv
// rtl/issue_regfile.sv - register file with two operand read ports, a debug read port and one prioritised write port
module issue_regfile
  import alu_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          i_resetn,
  input  logic          i_wb_we,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [DW-1:0] i_wb_data,
  input  logic          i_cfg_we,
  input  logic [AW-1:0] i_cfg_addr,
  input  logic [DW-1:0] i_cfg_data,
  input  logic [AW-1:0] i_rd_addr_a,
  output logic [DW-1:0] o_rd_data_a,
  input  logic [AW-1:0] i_rd_addr_b,
  output logic [DW-1:0] o_rd_data_b,
  input  logic [AW-1:0] i_dbg_addr,
  output logic [DW-1:0] o_dbg_data
);

  logic [DW-1:0] r_mem [NREGS];

  // Writeback wins; the controller never asserts both writes in the same cycle.
  always_ff @(posedge clk) begin
    if (!i_resetn) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_wb_we && (i_wb_addr != '0)) begin
      r_mem[i_wb_addr] <= i_wb_data;
    end else if (i_cfg_we && (i_cfg_addr != '0)) begin
      r_mem[i_cfg_addr] <= i_cfg_data;
    end
  end

  assign o_rd_data_a = (i_rd_addr_a == '0) ? '0 : r_mem[i_rd_addr_a];
  assign o_rd_data_b = (i_rd_addr_b == '0) ? '0 : r_mem[i_rd_addr_b];
  assign o_dbg_data  = (i_dbg_addr  == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issues R-type instructions to an external ALU and writes results back to the register file
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [31:0]   instr,
  output logic [DW-1:0] alu_dataA,
  output logic [DW-1:0] alu_dataB,
  output logic [5:0]    alu_Signal,
  input  logic [DW-1:0] alu_dataOut,
  output logic          wb_valid,
  output logic [4:0]    wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          err,
  input  logic          cfg_we,
  input  logic [4:0]    cfg_addr,
  input  logic [DW-1:0] cfg_data,
  input  logic [4:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  state_t        r_state;
  logic          r_ready;
  logic          r_wb_valid;
  logic [4:0]    r_wb_addr;
  logic [DW-1:0] r_wb_data;
  logic          r_err;
  logic [5:0]    r_opcode;
  logic [4:0]    r_rs;
  logic [4:0]    r_rt;
  logic [4:0]    r_rd;
  logic [5:0]    r_funct;

  logic [DW-1:0] w_rd_a;
  logic [DW-1:0] w_rd_b;
  logic          w_exec;
  logic          w_wb_we;
  logic          w_cfg_we;
  logic          w_unused_shamt;

  assign w_unused_shamt = ^instr[10:6];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b1;
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_err      <= 1'b0;
      r_opcode   <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_funct    <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (instr_valid) begin
            r_opcode <= instr[31:26];
            r_rs     <= instr[25:21];
            r_rt     <= instr[20:16];
            r_rd     <= instr[15:11];
            r_funct  <= instr[5:0];
            r_ready  <= 1'b0;
            r_state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          r_state <= is_legal(r_opcode, r_funct) ? ST_EXEC : ST_ERR;
        end
        ST_EXEC: begin
          r_wb_valid <= 1'b1;
          r_wb_addr  <= r_rd;
          r_wb_data  <= alu_dataOut;
          r_state    <= ST_WB;
        end
        // Illegal path passes through WB with wb_valid low so err lands in the same slot as a writeback.
        ST_ERR: begin
          r_err   <= 1'b1;
          r_state <= ST_WB;
        end
        ST_WB: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_exec   = (r_state == ST_EXEC);
  assign w_wb_we  = r_wb_valid;
  assign w_cfg_we = cfg_we && (r_state == ST_IDLE);

  issue_regfile #(
    .NREGS (NREGS),
    .DW    (DW),
    .AW    (5)
  ) u_regfile (
    .clk         (clk),
    .i_resetn    (reset),
    .i_wb_we     (w_wb_we),
    .i_wb_addr   (r_wb_addr),
    .i_wb_data   (r_wb_data),
    .i_cfg_we    (w_cfg_we),
    .i_cfg_addr  (cfg_addr),
    .i_cfg_data  (cfg_data),
    .i_rd_addr_a (r_rs),
    .o_rd_data_a (w_rd_a),
    .i_rd_addr_b (r_rt),
    .o_rd_data_b (w_rd_b),
    .i_dbg_addr  (dbg_addr),
    .o_dbg_data  (dbg_data)
  );

  assign alu_dataA   = w_exec ? w_rd_a  : '0;
  assign alu_dataB   = w_exec ? w_rd_b  : '0;
  assign alu_Signal  = w_exec ? r_funct : '0;
  assign instr_ready = r_ready;
  assign wb_valid    = r_wb_valid;
  assign wb_addr     = r_wb_addr;
  assign wb_data     = r_wb_data;
  assign err         = r_err;

endmodule
